mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
- Multi-cycle multiply/divide engine with its own sequencing FSM.
- Sits between the main control unit and the HI/LO registers. Replaces the separate combinational Div/Mult sources feeding the HI/LO muxes.
- Control unit pulses a start and waits on `busy`/`done`. The block performs 32 shift-add or restore-subtract iterations, then issues HI/LO load strobes.
- Raises a one-cycle divide-by-zero flag for the exception path.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_mult  input  1  request signed MULT; sampled only in IDLE.
- start_div  input  1  request signed DIV; sampled only in IDLE.
- op_a  input  WIDTH  rs operand (register A); latched on the accepting edge.
- op_b  input  WIDTH  rt operand (register B); latched on the accepting edge.
- hi_out  output  WIDTH  MULT: product[63:32]; DIV: remainder.
- lo_out  output  WIDTH  MULT: product[31:0]; DIV: quotient.
- hi_load  output  1  write strobe to the HI register.
- lo_load  output  1  write strobe to the LO register.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when a result is valid.
- div_zero  output  1  one-cycle pulse when DIV is requested with op_b == 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, iteration counter=0, internal operands cleared. hi_out=0, lo_out=0, hi_load=0, lo_load=0, busy=0, done=0, div_zero=0. An operation in progress is abandoned; no strobes are issued for it.
- States: IDLE, MULT, DIV, DONE, EXC.
- IDLE:
  - start_mult=1 -> MULT. This takes priority when start_mult and start_div are high on the same edge; start_div is dropped.
  - Otherwise start_div=1 and op_b!=0 -> DIV.
  - Otherwise start_div=1 and op_b==0 -> EXC.
  - On acceptance: latch |op_a|, |op_b|, result sign (a_sign XOR b_sign), dividend sign (a_sign); clear the counter.
- MULT: radix-2 shift-add on the magnitudes, one multiplier bit per cycle, 2*WIDTH-bit accumulator. After WIDTH cycles -> DONE.
- DIV: restoring division on the magnitudes, one quotient bit per cycle. After WIDTH cycles -> DONE.
- DONE (one cycle), then -> IDLE:
  - Negate the product or quotient if the result sign is set.
  - Give the remainder the sign of the dividend (quotient truncates toward zero).
  - Drive hi_out/lo_out; assert done=1, hi_load=1, lo_load=1.
- EXC (one cycle), then -> IDLE: div_zero=1; hi_load/lo_load stay 0; hi_out/lo_out keep their previous values.
- Latency, with edge k being the accepting edge:
  - MULT/DIV occupies the cycles after edges k..k+31.
  - DONE is the cycle after edge k+32; done is visible 33 cycles after the request.
  - EXC is the cycle after edge k.
  - Back-to-back issue is possible on the edge that leaves DONE or EXC.
- hi_out/lo_out hold their last result until the next DONE.
- start_mult/start_div are ignored while busy=1; the requester must re-assert them after done.
- op_a/op_b may change after the accepting edge without affecting the result.
- Overflow case: -2^31 / -1 yields lo_out=0x80000000, hi_out=0; no flag.
- Magnitude of -2^31 is computed in WIDTH+1 bits so that 0x80000000 operands are handled correctly.

Optional Feature:
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), after start_div, sampled on the accepting edge.
  - When 1: no magnitude conversion and no sign fix-up (MULTU/DIVU).
  - Latency is unchanged; the divide-by-zero rule still applies.
- Undefined: the port is absent; all operations are signed.

Test Plan:
- MULT 7 x -3 (op_a=7, op_b=0xFFFFFFFD) -> 33 cycles after the request: done=1, hi_load=lo_load=1, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB. busy=1 for exactly 33 cycles.
- DIV 7 / -2 -> lo_out=0xFFFFFFFD (-3), hi_out=0x00000001, done after 33 cycles. Then DIV -7 / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- DIV 5 / 0 after a prior result of 0x12345678/0x9ABCDEF0 -> div_zero pulse on cycle 1, no done and no load strobes, hi_out/lo_out unchanged, busy low after 1 cycle.
- start_mult and start_div asserted together (op_a=0x80000000, op_b=0x80000000) -> MULT executed: hi_out=0x40000000, lo_out=0. A second start_div pulsed mid-operation is ignored.
- reset asserted at iteration 10 of a DIV -> all outputs 0 immediately (asynchronously), no done pulse. A new MULT 3 x 4 afterwards gives lo_out=12, hi_out=0.
- With MULT_DIV_UNSIGNED_EN: is_unsigned=1, MULT 0xFFFFFFFF x 2 -> hi_out=0x00000001, lo_out=0xFFFFFFFE. DIV 0xFFFFFFFF / 0x10 -> lo_out=0x0FFFFFFF, hi_out=0xF.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// Multi-cycle signed multiply/divide engine feeding the HI/LO registers.
// Optional MULTU/DIVU support via `define MULT_DIV_UNSIGNED_EN (adds is_unsigned port).
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// MULT  | shift-add iterations on magnitudes
// DIV   | restoring-divide iterations on magnitudes
// DONE  | sign fix-up, result valid, HI/LO strobes
// EXC   | divide by zero, div_zero pulse
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_load,
    output logic             lo_load,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        DONE = 3'd3,
        EXC  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      cnt;
    logic               res_sign;
    logic               dvd_sign;
    logic               is_div;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic signed_op;
`ifdef MULT_DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Magnitudes are formed in WIDTH+1 bits so that -2^(WIDTH-1) maps to 2^(WIDTH-1).
    logic [WIDTH:0]   ext_a, ext_b, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign ext_a = {signed_op & op_a[WIDTH-1], op_a};
    assign ext_b = {signed_op & op_b[WIDTH-1], op_b};
    assign neg_a = -ext_a;
    assign neg_b = -ext_b;
    assign mag_a = ext_a[WIDTH] ? neg_a[WIDTH-1:0] : ext_a[WIDTH-1:0];
    assign mag_b = ext_b[WIDTH] ? neg_b[WIDTH-1:0] : ext_b[WIDTH-1:0];

    logic last_iter;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_nxt;
    assign mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
    assign mult_nxt = {mult_sum, acc[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_nxt;
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
    assign prod_fix = res_sign ? -acc : acc;
    assign quo_fix  = res_sign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = dvd_sign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mult)                    state_nxt = MULT;
                else if (start_div && op_b != '0)  state_nxt = DIV;
                else if (start_div)                state_nxt = EXC;
            end
            MULT:    if (last_iter) state_nxt = DONE;
            DIV:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            EXC:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        hi_load  = (state == DONE);
        lo_load  = (state == DONE);
        div_zero = (state == EXC);
        hi_out   = (state == DONE) ? res_hi : hi_reg;
        lo_out   = (state == DONE) ? res_lo : lo_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            b_reg    <= '0;
            cnt      <= '0;
            res_sign <= 1'b0;
            dvd_sign <= 1'b0;
            is_div   <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        acc      <= {{WIDTH{1'b0}}, mag_a};
                        b_reg    <= mag_b;
                        cnt      <= '0;
                        res_sign <= ext_a[WIDTH] ^ ext_b[WIDTH];
                        dvd_sign <= ext_a[WIDTH];
                        is_div   <= ~start_mult;
                    end
                end
                MULT: begin
                    acc <= mult_nxt;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    hi_reg <= res_hi;
                    lo_reg <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: vector table plus reset/priority corner sequences.
`timescale 1ns/1ps
module tb_mult_div_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
    logic        is_unsigned = 1'b0;
`endif
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] hi_out, lo_out;
    logic        hi_load, lo_load, busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    always #5 clock = ~clock;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned(is_unsigned),
`endif
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .hi_load    (hi_load),
        .lo_load    (lo_load),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_hi"}, hi_out, 32'h0);
        check({name, "_lo"}, lo_out, 32'h0);
        check({name, "_ctl"}, {27'd0, hi_load, lo_load, busy, done, div_zero}, 32'h0);
    endtask

    // Called just after a negedge; returns just after a negedge in the IDLE cycle.
    task automatic run_op(input string name, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ez, input bit mid_div);
        int bad;
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        if (ez) begin
            @(negedge clock);
            check({name, "_exc_ctl"}, {27'd0, hi_load, lo_load, busy, done, div_zero}, 32'h5);
            check({name, "_exc_hi"}, hi_out, prev_hi);
            check({name, "_exc_lo"}, lo_out, prev_lo);
            @(negedge clock);
            check({name, "_exc_end"}, {27'd0, hi_load, lo_load, busy, done, div_zero}, 32'h0);
        end else begin
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clock);
                if (!busy || done || hi_load || lo_load || div_zero) bad++;
                if (mid_div && i == 10) begin
                    start_div = 1'b1;
                    op_b      = 32'h0;
                end
                if (mid_div && i == 11) start_div = 1'b0;
            end
            check({name, "_run_bad_cycles"}, 32'(bad), 32'h0);
            @(negedge clock);
            check({name, "_done_ctl"}, {27'd0, hi_load, lo_load, busy, done, div_zero}, 32'h1E);
            check({name, "_hi"}, hi_out, eh);
            check({name, "_lo"}, lo_out, el);
            @(negedge clock);
            check({name, "_idle_ctl"}, {27'd0, hi_load, lo_load, busy, done, div_zero}, 32'h0);
            check({name, "_hold_hi"}, hi_out, eh);
            check({name, "_hold_lo"}, lo_out, el);
            prev_hi = eh;
            prev_lo = el;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        //        m     d     a             b             hi            lo            ez
        vecs[0]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h00000005, 32'h00000000, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};

        #3;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("post_reset");

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, vecs[i].ez, 1'b0);

        // Both starts together: MULT wins; a mid-operation divide-by-zero request is ignored.
        run_op("both_starts", 1'b1, 1'b1, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a DIV.
        start_div = 1'b1;
        op_a      = 32'd1000;
        op_b      = 32'd3;
        @(posedge clock);
        #1;
        start_div = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy || done || hi_load || lo_load || div_zero) bad++;
        end
        check("abandoned_op_activity", 32'(bad), 32'h0);
        prev_hi = '0;
        prev_lo = '0;
        run_op("mult_after_reset", 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

`ifdef MULT_DIV_UNSIGNED_EN
        is_unsigned = 1'b1;
        run_op("multu", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("divu", 1'b0, 1'b1, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0);
        run_op("divu_zero", 1'b0, 1'b1, 32'h7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        is_unsigned = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
